// File: rtl/order_pkt_fifo.sv
// Store-and-forward packet FIFO: admits or drops whole packets from a non-stallable source
// and replays committed packets through a single registered output stage.
module order_pkt_fifo #(
    parameter int DATA_W        = 256,
    parameter int DEPTH         = 16,
    parameter int MAX_PKT_BEATS = 4,
    parameter int CNT_W         = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic [DATA_W-1:0]          s_tdata,
    input  logic                       s_tvalid,
    input  logic                       s_tlast,
    input  logic [DATA_W/8-1:0]        s_tkeep,
    output logic                       s_tready,
    output logic [DATA_W-1:0]          m_tdata,
    output logic                       m_tvalid,
    output logic                       m_tlast,
    output logic [DATA_W/8-1:0]        m_tkeep,
    output logic [DATA_W/8-1:0]        m_tstrb,
    input  logic                       m_tready,
    output logic [$clog2(DEPTH):0]     pkt_cnt,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic                       drop_pulse
);

    localparam int KEEP_W = DATA_W / 8;
    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int ENT_W  = 1 + KEEP_W + DATA_W;
    localparam int BC_W   = $clog2(MAX_PKT_BEATS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCEPT  = 2'd1,
        DISCARD = 2'd2
    } wr_state_t;

    wr_state_t          state, state_nxt;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]   wr_commit, wr_commit_nxt;
    logic [PTR_W-1:0]   rd_ptr;
    logic [BC_W-1:0]    beat_cnt, beat_cnt_nxt;
    logic               mem_we;
    logic               commit;
    logic               drop;
    logic [PTR_W-1:0]   used;
    logic [PTR_W:0]     free;
    logic               has_room;
    logic               load;
    logic               out_last;
    logic [ENT_W-1:0]   entry;

    logic [ENT_W-1:0]   mem [DEPTH];

    // Free space counts only committed data; the reservation taken at packet start covers
    // the beats of the packet still being written.
    assign used     = wr_commit - rd_ptr;
    assign free     = (PTR_W+1)'(DEPTH) - {1'b0, used};
    assign has_room = free >= (PTR_W+1)'(MAX_PKT_BEATS);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            wr_commit <= '0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            wr_commit <= wr_commit_nxt;
            beat_cnt  <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        wr_commit_nxt = wr_commit;
        beat_cnt_nxt  = beat_cnt;
        mem_we        = 1'b0;
        commit        = 1'b0;
        drop          = 1'b0;
        if (s_tvalid) begin
            case (state)
                IDLE: begin
                    if (has_room) begin
                        mem_we       = 1'b1;
                        wr_ptr_nxt   = wr_ptr + PTR_W'(1);
                        beat_cnt_nxt = BC_W'(1);
                        if (s_tlast) begin
                            commit        = 1'b1;
                            wr_commit_nxt = wr_ptr + PTR_W'(1);
                        end else begin
                            state_nxt = ACCEPT;
                        end
                    end else begin
                        drop = 1'b1;
                        if (!s_tlast) state_nxt = DISCARD;
                    end
                end
                ACCEPT: begin
                    // Any beat beyond MAX_PKT_BEATS, even one carrying tlast, kills the packet
                    // so the reservation can never be overrun.
                    if (beat_cnt == BC_W'(MAX_PKT_BEATS)) begin
                        drop       = 1'b1;
                        wr_ptr_nxt = wr_commit;
                        state_nxt  = s_tlast ? IDLE : DISCARD;
                    end else begin
                        mem_we       = 1'b1;
                        wr_ptr_nxt   = wr_ptr + PTR_W'(1);
                        beat_cnt_nxt = beat_cnt + BC_W'(1);
                        if (s_tlast) begin
                            commit        = 1'b1;
                            wr_commit_nxt = wr_ptr + PTR_W'(1);
                            state_nxt     = IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (s_tlast) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tkeep, s_tdata};
    end

    assign entry    = mem[rd_ptr[AW-1:0]];
    assign load     = (!m_tvalid || m_tready) && (rd_ptr != wr_commit);
    assign out_last = m_tvalid && m_tready && m_tlast;
    assign m_tstrb  = m_tkeep;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tkeep  <= '0;
            m_tdata  <= '0;
            rd_ptr   <= '0;
        end else if (load) begin
            {m_tlast, m_tkeep, m_tdata} <= entry;
            m_tvalid <= 1'b1;
            rd_ptr   <= rd_ptr + PTR_W'(1);
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
            s_tready   <= 1'b0;
        end else begin
            s_tready   <= 1'b1;
            drop_pulse <= drop;
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            case ({commit, out_last})
                2'b10:   pkt_cnt <= pkt_cnt + PTR_W'(1);
                2'b01:   pkt_cnt <= pkt_cnt - PTR_W'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_order_pkt_fifo.sv
// Self-checking bench for order_pkt_fifo: cycle-exact vector table for the basic path,
// then directed sequences with a scoreboard for drops, stalls, saturation and reset.
module tb_order_pkt_fifo;

    localparam int DATA_W = 256;
    localparam int KEEP_W = DATA_W / 8;
    localparam int DEPTH  = 16;
    localparam int MAXB   = 4;
    localparam int CNT_W  = 4;
    localparam int PCW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              resetn;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid;
    logic              s_tlast;
    logic [KEEP_W-1:0] s_tkeep;
    logic              s_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic [KEEP_W-1:0] m_tkeep;
    logic [KEEP_W-1:0] m_tstrb;
    logic              m_tready;
    logic [PCW-1:0]    pkt_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              drop_pulse;

    order_pkt_fifo #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_PKT_BEATS(MAXB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tkeep(s_tkeep),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tkeep(m_tkeep),
        .m_tstrb(m_tstrb), .m_tready(m_tready),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          last;
        int unsigned sn;
    } beat_t;

    typedef struct {
        bit          vld;
        bit          lst;
        int unsigned sn;
        bit          rdy;
        bit          e_vld;
        bit          e_lst;
        int unsigned e_sn;
        int unsigned e_pkt;
        int unsigned e_drop;
        bit          e_pulse;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned rx_beats = 0;
    int unsigned rx_lasts = 0;
    int unsigned pulse_cnt = 0;
    int unsigned sn = 100;
    bit          mon_en = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          prev_stall = 1'b0;
    logic [DATA_W-1:0] hold_data;
    logic [KEEP_W-1:0] hold_keep;
    logic              hold_last;
    beat_t       exp_q[$];

    function automatic logic [DATA_W-1:0] dat(input int unsigned n);
        logic [31:0] w;
        w = n;
        return {8{w}};
    endfunction

    function automatic logic [KEEP_W-1:0] kp(input int unsigned n);
        logic [15:0] h;
        h = n[15:0];
        return {h ^ 16'h5a5a, h};
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) m_tready = ($urandom_range(0, 1) == 1);
    endtask

    // Output monitor: scoreboard compare on each handshake and hold check while stalled.
    always @(negedge clk) begin
        if (!resetn || !mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_data", m_tdata, hold_data);
                check("stall_keep", m_tkeep, hold_keep);
                check("stall_last", m_tlast, hold_last);
            end
            if (m_tvalid && m_tready) begin
                beat_t e;
                rx_beats++;
                if (m_tlast) rx_lasts++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got data %0h expected no beat", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", m_tdata, dat(e.sn));
                    check("out_keep", m_tkeep, kp(e.sn));
                    check("out_strb", m_tstrb, kp(e.sn));
                    check("out_last", m_tlast, e.last);
                end
            end
            prev_stall = m_tvalid && !m_tready;
            hold_data  = m_tdata;
            hold_keep  = m_tkeep;
            hold_last  = m_tlast;
        end
        if (drop_pulse) pulse_cnt++;
    end

    task automatic reset_dut();
        resetn   = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        m_tready = 1'b0;
        rand_rdy = 1'b0;
        exp_q.delete();
        tick();
        tick();
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_s_tready", s_tready, 0);
        resetn = 1'b1;
        tick();
        check("s_tready_up", s_tready, 1);
    endtask

    task automatic send_beat(input bit last, input bit admit);
        beat_t b;
        s_tvalid = 1'b1;
        s_tlast  = last;
        s_tdata  = dat(sn);
        s_tkeep  = kp(sn);
        if (admit) begin
            b.last = last;
            b.sn   = sn;
            exp_q.push_back(b);
        end
        sn++;
        tick();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int unsigned len, input bit admit);
        for (int unsigned i = 0; i < len; i++) send_beat(i == len - 1, admit);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick();
            c++;
        end
        check("drain_pending", exp_q.size(), 0);
        idle(3);
    endtask

    vec_t tbl[11];

    initial begin
        int unsigned b0, l0, p0;

        // vld lst sn rdy | e_vld e_lst e_sn e_pkt e_drop e_pulse
        tbl[0]  = '{1, 0, 1, 1,  0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 2, 1,  0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 3, 1,  0, 0, 0, 1, 0, 0};
        tbl[3]  = '{0, 0, 0, 1,  1, 0, 1, 1, 0, 0};
        tbl[4]  = '{0, 0, 0, 1,  1, 0, 2, 1, 0, 0};
        tbl[5]  = '{0, 0, 0, 1,  1, 1, 3, 1, 0, 0};
        tbl[6]  = '{0, 0, 0, 1,  0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 1, 4, 0,  0, 0, 0, 1, 0, 0};
        tbl[8]  = '{0, 0, 0, 0,  1, 1, 4, 1, 0, 0};
        tbl[9]  = '{0, 0, 0, 0,  1, 1, 4, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 1,  0, 0, 0, 0, 0, 0};

        reset_dut();
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tkeep", m_tkeep, 0);
        check("rst_drop_pulse", drop_pulse, 0);

        // Basic path, cycle exact
        for (int i = 0; i < 11; i++) begin
            s_tvalid = tbl[i].vld;
            s_tlast  = tbl[i].lst;
            s_tdata  = dat(tbl[i].sn);
            s_tkeep  = kp(tbl[i].sn);
            m_tready = tbl[i].rdy;
            tick();
            check($sformatf("v%0d_valid", i), m_tvalid, tbl[i].e_vld);
            check($sformatf("v%0d_pkt_cnt", i), pkt_cnt, tbl[i].e_pkt);
            check($sformatf("v%0d_drop_cnt", i), drop_cnt, tbl[i].e_drop);
            check($sformatf("v%0d_pulse", i), drop_pulse, tbl[i].e_pulse);
            if (tbl[i].e_vld) begin
                check($sformatf("v%0d_last", i), m_tlast, tbl[i].e_lst);
                check($sformatf("v%0d_data", i), m_tdata, dat(tbl[i].e_sn));
                check($sformatf("v%0d_strb", i), m_tstrb, kp(tbl[i].e_sn));
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;

        // Six back-to-back packets into a stalled output: the sixth does not fit
        reset_dut();
        mon_en = 1'b1;
        p0 = pulse_cnt;
        for (int unsigned k = 0; k < 6; k++) send_pkt(3, k < 5);
        idle(2);
        check("fill_pkt_cnt", pkt_cnt, 5);
        check("fill_drop_cnt", drop_cnt, 1);
        check("fill_pulses", pulse_cnt - p0, 1);
        check("fill_head_valid", m_tvalid, 1);
        b0 = rx_beats;
        l0 = rx_lasts;
        m_tready = 1'b1;
        wait_drain(100);
        check("fill_rx_beats", rx_beats - b0, 15);
        check("fill_rx_lasts", rx_lasts - l0, 5);
        check("fill_pkt_cnt_end", pkt_cnt, 0);

        // Oversize packets: tlast on beat 5, then no tlast until beat 6
        reset_dut();
        m_tready = 1'b1;
        p0 = pulse_cnt;
        send_pkt(5, 0);
        send_pkt(3, 1);
        wait_drain(50);
        check("ovs5_drop_cnt", drop_cnt, 1);
        send_pkt(6, 0);
        send_pkt(2, 1);
        wait_drain(50);
        check("ovs6_drop_cnt", drop_cnt, 2);
        check("ovs_pulses", pulse_cnt - p0, 2);
        check("ovs_pkt_cnt", pkt_cnt, 0);

        // Drop counter saturation with a 4-bit counter
        reset_dut();
        for (int unsigned k = 0; k < 5; k++) send_pkt(3, 1);
        p0 = pulse_cnt;
        for (int unsigned k = 0; k < 14; k++) send_pkt(1, 0);
        idle(2);
        check("sat_drop_cnt_14", drop_cnt, 14);
        for (int unsigned k = 0; k < 3; k++) send_pkt(1, 0);
        idle(2);
        check("sat_drop_cnt_17", drop_cnt, 15);
        check("sat_pulses", pulse_cnt - p0, 17);
        check("sat_pkt_cnt", pkt_cnt, 5);
        m_tready = 1'b1;
        wait_drain(100);

        // Reset in the middle of a packet while the output holds a stalled beat
        m_tready = 1'b0;
        send_pkt(1, 0);
        send_beat(0, 0);
        send_beat(0, 0);
        idle(1);
        check("prerst_valid", m_tvalid, 1);
        check("prerst_drop_cnt", drop_cnt, 15);
        resetn = 1'b0;
        tick();
        check("midrst_valid", m_tvalid, 0);
        check("midrst_last", m_tlast, 0);
        check("midrst_data", m_tdata, 0);
        check("midrst_keep", m_tkeep, 0);
        check("midrst_pkt_cnt", pkt_cnt, 0);
        check("midrst_drop_cnt", drop_cnt, 0);
        check("midrst_pulse", drop_pulse, 0);
        check("midrst_s_tready", s_tready, 0);
        resetn = 1'b1;
        tick();
        m_tready = 1'b1;
        send_pkt(3, 1);
        wait_drain(50);
        check("postrst_pkt_cnt", pkt_cnt, 0);
        check("postrst_drop_cnt", drop_cnt, 0);

        // Random backpressure over 200 packets, paced so none can be dropped
        reset_dut();
        b0 = rx_beats;
        rand_rdy = 1'b1;
        begin
            int unsigned sent = 0;
            for (int unsigned k = 0; k < 200; k++) begin
                int unsigned c = 0;
                int unsigned len;
                while ((sent - (rx_beats - b0)) > DEPTH - MAXB && c < 500) begin
                    tick();
                    c++;
                end
                if (c >= 500) check("pace_timeout", sent - (rx_beats - b0), DEPTH - MAXB);
                len = $urandom_range(1, MAXB);
                send_pkt(len, 1);
                sent += len;
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            wait_drain(3000);
            check("rand_rx_beats", rx_beats - b0, sent);
        end
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        idle(2);
        check("rand_drop_cnt", drop_cnt, 0);
        check("rand_pkt_cnt", pkt_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end

endmodule
